// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the packed-vector producer blocks that feed the
// dot-product multiplier.
//
// Contents:
//   state_e     - packer FSM states (FILL, PAD, FULL)
//   DEFAULT_N   - default number of elements per vector
//   DEFAULT_W   - default element width in bits
//   cntWidth()  - width needed for an element counter that must reach n
// ---------------------------------------------------------------------------
package vec_pkg;

   // FILL takes elements, PAD shifts in zeros after an early last,
   // FULL presents the finished pair downstream.
   typedef enum logic [1:0] {
      FILL = 2'd0,
      PAD  = 2'd1,
      FULL = 2'd2
   } state_e;

   localparam int DEFAULT_N = 3;
   localparam int DEFAULT_W = 8;

   // Counters have to hold the value n itself, not just n-1.
   function automatic int cntWidth(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/packed_shift_reg.sv
// ---------------------------------------------------------------------------
// packed_shift_reg
// N-slot shift register of W-bit elements packed into one N*W-bit bus.
// Each shift moves every element up by one slot and inserts din at the
// least-significant slot. The first element shifted in therefore ends up
// in the most-significant slot once N shifts have occurred.
//
// Ports:
//   clk       in   1     rising-edge clock
//   rst       in   1     asynchronous reset, active-low
//   clear     in   1     synchronous clear to zero (wins over shift_en)
//   shift_en  in   1     shift left by W and insert din
//   din       in   W     element inserted at the LSB slot
//   q         out  N*W   packed contents
// ---------------------------------------------------------------------------
module packed_shift_reg #(
   parameter int N = 3,
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clear,
   input  logic           shift_en,
   input  logic [W-1:0]   din,
   output logic [N*W-1:0] q
);

   // Clear takes priority so a completed vector is wiped in the same cycle
   // it is handed off; otherwise shift only when asked, else hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (shift_en) begin
         q <= {q[N*W-W-1:0], din};
      end
   end

endmodule

// File: rtl/vector_pair_packer.sv
// ---------------------------------------------------------------------------
// vector_pair_packer
// Collects (a_i, b_i) element pairs from a serial valid/ready stream and
// assembles them into packed N*W-bit vectors A and B for the dot-product
// multiplier. A vector ends either after N elements or early on in_last;
// an early end is zero-padded up to N so the downstream dot product sees
// zeros in the unused slots. The finished pair is offered with its own
// valid/ready handshake and held stable until taken.
//
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous reset, active-low
//   in_valid   in   1     element pair valid
//   in_ready   out  1     packer can accept an element (FILL state)
//   in_a       in   W     element of vector A
//   in_b       in   W     element of vector B
//   in_last    in   1     final element of this vector (sampled on accept)
//   out_valid  out  1     packed pair complete and stable (FULL state)
//   out_ready  in   1     consumer takes the packed pair
//   A          out  N*W   packed vector A, element 0 in the top W bits
//   B          out  N*W   packed vector B, same layout
//   len        out  CW    count of real (non-padded) elements, 1..N
// ---------------------------------------------------------------------------
module vector_pair_packer
   import vec_pkg::*;
#(
   parameter  int N  = DEFAULT_N,
   parameter  int W  = DEFAULT_W,
   localparam int CW = cntWidth(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   input  logic           in_last,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] A,
   output logic [N*W-1:0] B,
   output logic [CW-1:0]  len
);

   state_e        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] nextCnt;
   logic          accept;
   logic          take;
   logic          lastSlot;
   logic          shiftEn;
   logic          clearVec;
   logic [W-1:0]  dinA;
   logic [W-1:0]  dinB;

   // Handshake flags come straight from the state register so neither
   // ready nor valid has a combinational path from any input.
   assign in_ready  = (state == FILL);
   assign out_valid = (state == FULL);
   assign accept    = in_valid && in_ready;
   assign take      = out_valid && out_ready;

   // nextCnt == N marks the element (or pad slot) that completes a vector.
   assign nextCnt  = cnt + CW'(1);
   assign lastSlot = (nextCnt == CW'(N));

   // The shifters move on a real accept in FILL and on every PAD cycle;
   // PAD inserts zeros. Handing off a finished pair clears both buses so
   // the next vector starts from a clean all-zero state.
   always_comb begin
      shiftEn  = 1'b0;
      clearVec = 1'b0;
      dinA     = in_a;
      dinB     = in_b;
      case (state)
         FILL: shiftEn = accept;
         PAD: begin
            shiftEn = 1'b1;
            dinA    = '0;
            dinB    = '0;
         end
         FULL:    clearVec = take;
         default: ;
      endcase
   end

   packed_shift_reg #(.N(N), .W(W)) u_shift_a (
      .clk      (clk),
      .rst      (rst),
      .clear    (clearVec),
      .shift_en (shiftEn),
      .din      (dinA),
      .q        (A)
   );

   packed_shift_reg #(.N(N), .W(W)) u_shift_b (
      .clk      (clk),
      .rst      (rst),
      .clear    (clearVec),
      .shift_en (shiftEn),
      .din      (dinB),
      .q        (B)
   );

   // Packer FSM. cnt counts slots filled so far, real or padded, and so
   // reaches N exactly when the buses are complete. in_last is ignored on
   // the N-th element because the vector is already full at that point.
   // len is held through FULL and only overwritten by the next vector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
         cnt   <= '0;
         len   <= '0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  cnt <= nextCnt;
                  if (lastSlot) begin
                     len   <= CW'(N);
                     state <= FULL;
                  end else if (in_last) begin
                     len   <= nextCnt;
                     state <= PAD;
                  end
               end
            end
            PAD: begin
               cnt <= nextCnt;
               if (lastSlot) begin
                  state <= FULL;
               end
            end
            FULL: begin
               if (take) begin
                  cnt   <= '0;
                  state <= FILL;
               end
            end
            default: begin
               cnt   <= '0;
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_pair_packer.sv
// ---------------------------------------------------------------------------
// tb_vector_pair_packer
// Directed self-checking bench for vector_pair_packer with N=3, W=8.
// Expected values are hand-computed packed constants (element 0 in the top
// byte) plus a small shift model for the gapped-valid run.
// ---------------------------------------------------------------------------
module tb_vector_pair_packer;

   localparam int N  = 3;
   localparam int W  = 8;
   localparam int CW = 2;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic           in_last;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] A;
   logic [N*W-1:0] B;
   logic [CW-1:0]  len;

   int checks = 0;
   int errors = 0;

   vector_pair_packer #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .A         (A),
      .B         (B),
      .len       (len)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge; inputs and checks both
   // happen at this point, well clear of the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present one element and hold it until it is accepted (bounded wait).
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic last);
      int waited;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      waited   = 0;
      while (!in_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!in_ready) begin
         checkOutput("acceptWait", 32'(in_ready), 32'd1);
      end else begin
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Single-cycle take of the packed pair.
   task automatic takeOutput();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   function automatic int dotProduct(input logic [N*W-1:0] va,
                                     input logic [N*W-1:0] vb);
      int sum = 0;
      for (int i = 0; i < N; i++) begin
         sum += int'(va[i*W +: W]) * int'(vb[i*W +: W]);
      end
      return sum;
   endfunction

   initial begin
      logic [N*W-1:0] expA;
      logic [N*W-1:0] expB;
      logic [W-1:0]   elemA [3];
      logic [W-1:0]   elemB [3];
      int             idx;
      logic           wasReady;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      // Reset state while rst is held low.
      #2;
      checkOutput("rstA", 32'(A), 32'h0);
      checkOutput("rstB", 32'(B), 32'h0);
      checkOutput("rstLen", 32'(len), 32'd0);
      checkOutput("rstOutValid", 32'(out_valid), 32'd0);
      #10 rst = 1'b1;
      tick();
      checkOutput("rstInReady", 32'(in_ready), 32'd1);

      // Full-length vector {1,2,3} with last on the third element.
      $display("[TB] full vector 1,2,3");
      applyStimulus(8'd1, 8'd1, 1'b0);
      applyStimulus(8'd2, 8'd2, 1'b0);
      checkOutput("fullNotYet", 32'(out_valid), 32'd0);
      applyStimulus(8'd3, 8'd3, 1'b1);
      checkOutput("fullOutValid", 32'(out_valid), 32'd1);
      checkOutput("fullInReady", 32'(in_ready), 32'd0);
      checkOutput("fullA", 32'(A), 32'h010203);
      checkOutput("fullB", 32'(B), 32'h010203);
      checkOutput("fullLen", 32'(len), 32'd3);
      checkOutput("fullDot", 32'(dotProduct(A, B)), 32'd14);
      takeOutput();
      checkOutput("takeInReady", 32'(in_ready), 32'd1);
      checkOutput("takeOutValid", 32'(out_valid), 32'd0);
      checkOutput("takeA", 32'(A), 32'h0);

      // Short vector {10,5}: one pad cycle.
      $display("[TB] short vector 10,5");
      applyStimulus(8'd10, 8'd10, 1'b0);
      applyStimulus(8'd5, 8'd5, 1'b1);
      checkOutput("pad2InReady", 32'(in_ready), 32'd0);
      checkOutput("pad2OutValid", 32'(out_valid), 32'd0);
      checkOutput("pad2Partial", 32'(A), 32'h000A05);
      tick();
      checkOutput("short2OutValid", 32'(out_valid), 32'd1);
      checkOutput("short2A", 32'(A), 32'h0A0500);
      checkOutput("short2B", 32'(B), 32'h0A0500);
      checkOutput("short2Len", 32'(len), 32'd2);
      takeOutput();

      // Single-element vector {2}: two pad cycles.
      $display("[TB] short vector 2");
      applyStimulus(8'd2, 8'd2, 1'b1);
      checkOutput("pad1aOutValid", 32'(out_valid), 32'd0);
      tick();
      checkOutput("pad1bOutValid", 32'(out_valid), 32'd0);
      checkOutput("pad1bInReady", 32'(in_ready), 32'd0);
      tick();
      checkOutput("short1OutValid", 32'(out_valid), 32'd1);
      checkOutput("short1A", 32'(A), 32'h020000);
      checkOutput("short1Len", 32'(len), 32'd1);

      // Output stall: in_valid high, nothing may be consumed.
      $display("[TB] output stall");
      in_valid = 1'b1;
      in_a     = 8'hFF;
      in_b     = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("stallInReady", 32'(in_ready), 32'd0);
         checkOutput("stallA", 32'(A), 32'h020000);
         checkOutput("stallOutValid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      takeOutput();
      checkOutput("stallTakeInReady", 32'(in_ready), 32'd1);
      checkOutput("stallTakeA", 32'(A), 32'h0);
      checkOutput("stallTakeB", 32'(B), 32'h0);

      // Back-to-back {1,2,3} then {10,5,2} with valid and ready held high.
      $display("[TB] back-to-back vectors");
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a = 8'd1;  in_b = 8'd1;  tick();
      in_a = 8'd2;  in_b = 8'd2;  tick();
      in_a = 8'd3;  in_b = 8'd3;  tick();
      checkOutput("b2bFirstValid", 32'(out_valid), 32'd1);
      checkOutput("b2bFirstA", 32'(A), 32'h010203);
      checkOutput("b2bFirstInReady", 32'(in_ready), 32'd0);
      in_a = 8'd10; in_b = 8'd10; tick();
      checkOutput("b2bIdleInReady", 32'(in_ready), 32'd1);
      checkOutput("b2bIdleA", 32'(A), 32'h0);
      tick();
      in_a = 8'd5;  in_b = 8'd5;  tick();
      in_a = 8'd2;  in_b = 8'd2;  in_last = 1'b1; tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      checkOutput("b2bSecondValid", 32'(out_valid), 32'd1);
      checkOutput("b2bSecondA", 32'(A), 32'h0A0502);
      checkOutput("b2bSecondLen", 32'(len), 32'd3);
      tick();
      out_ready = 1'b0;
      checkOutput("b2bDrained", 32'(in_ready), 32'd1);

      // Random valid gaps; expected buses tracked with a shift model.
      $display("[TB] gapped valid");
      elemA[0] = 8'd4; elemA[1] = 8'd5; elemA[2] = 8'd6;
      elemB[0] = 8'd7; elemB[1] = 8'd8; elemB[2] = 8'd9;
      expA = '0;
      expB = '0;
      idx  = 0;
      for (int cyc = 0; cyc < 60 && idx < 3; cyc++) begin
         in_valid = ($urandom_range(1, 0) == 1);
         in_a     = elemA[idx];
         in_b     = elemB[idx];
         in_last  = (idx == 2);
         wasReady = in_ready;
         tick();
         if (in_valid && wasReady) begin
            expA = {expA[N*W-W-1:0], elemA[idx]};
            expB = {expB[N*W-W-1:0], elemB[idx]};
            idx++;
         end
         if (idx < 3) begin
            checkOutput("gapA", 32'(A), 32'(expA));
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checkOutput("gapAllAccepted", 32'(idx), 32'd3);
      checkOutput("gapOutValid", 32'(out_valid), 32'd1);
      checkOutput("gapA", 32'(A), 32'h040506);
      checkOutput("gapB", 32'(B), 32'h070809);
      checkOutput("gapLen", 32'(len), 32'd3);
      takeOutput();

      // Asynchronous reset between edges after two accepts.
      $display("[TB] async reset mid-fill");
      applyStimulus(8'd1, 8'd1, 1'b0);
      applyStimulus(8'd2, 8'd2, 1'b0);
      checkOutput("preRstA", 32'(A), 32'h000102);
      #3 rst = 1'b0;
      #1;
      checkOutput("asyncRstA", 32'(A), 32'h0);
      checkOutput("asyncRstB", 32'(B), 32'h0);
      checkOutput("asyncRstOutValid", 32'(out_valid), 32'd0);
      #1 rst = 1'b1;
      tick();
      applyStimulus(8'd1, 8'd1, 1'b0);
      applyStimulus(8'd2, 8'd2, 1'b0);
      applyStimulus(8'd3, 8'd3, 1'b0);
      checkOutput("postRstOutValid", 32'(out_valid), 32'd1);
      checkOutput("postRstA", 32'(A), 32'h010203);
      checkOutput("postRstLen", 32'(len), 32'd3);
      takeOutput();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_pair_packer.md
Name: vector_pair_packer

Overview:
- Producer end of the packed-vector interface consumed by the dot-product multiplier.
- Accepts element pairs (a_i, b_i) one per handshake on a serial valid/ready stream and assembles them into packed N*W-bit buses A and B.
- Presents the completed pair with an output valid/ready handshake.
- Supports early termination with zero padding, so short vectors yield correct dot products downstream.

Parameters:
- N, 3, number of elements per vector (N >= 2)
- W, 8, element width in bits
- CW, $clog2(N+1), width of element counters (derived localparam, not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
- in_valid  input  1  element pair valid
- in_ready  output  1  packer can accept an element
- in_a  input  W  element of vector A
- in_b  input  W  element of vector B
- in_last  input  1  qualifies in_a/in_b as final element of this vector; sampled only on accept
- out_valid  output  1  packed pair A/B is complete and stable
- out_ready  input  1  consumer takes the packed pair
- A  output  N*W  packed vector A; element 0 (first received) in bits [N*W-1 -: W]
- B  output  N*W  packed vector B, same layout as A
- len  output  CW  number of real (non-padded) elements in A/B, 1..N

Behaviour:
- Reset (rst=0, async): state=FILL, A=0, B=0, len=0, cnt=0, out_valid=0. in_ready=1 as soon as rst deasserts.
- Accept = in_valid && in_ready. Output take = out_valid && out_ready.
- All outputs are registered. in_ready and out_valid are decoded directly from the state register and depend on no input combinationally.
- FSM states:
  - FILL: in_ready=1, out_valid=0.
  - PAD: in_ready=0, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- FILL, on accept:
  - A <= {A[N*W-W-1:0], in_a}, B likewise (shift left by W, insert at LSB); cnt <= cnt+1.
  - If cnt+1 == N: go to FULL, len <= N. in_last is ignored on the N-th element.
  - Else if in_last: len <= cnt+1, go to PAD.
  - Else stay in FILL.
- PAD: each cycle A and B shift left by W with zero insert; cnt <= cnt+1. When cnt+1 == N, go to FULL. Padding therefore takes N-len cycles.
- FULL: A, B and len are held stable. On take, go to FILL with cnt <= 0 and A, B <= 0. in_ready rises the cycle after the take. No same-cycle refill.
- Latency:
  - Full-length vector: out_valid is high in the cycle after the N-th accept.
  - Short vector of k elements: out_valid rises 1+(N-k) cycles after the last accept.
- Throughput: N+1 cycles per full vector under continuous valid/ready.
- A stall on out_ready holds the block in FULL indefinitely. Inputs are ignored: in_ready=0, so nothing is consumed.
- in_valid may toggle freely in FILL. Cycles without an accept leave A, B and cnt unchanged.
- Reset mid-fill or mid-pad discards the partial vector. Next vector starts at element 0.
- Width rules: no arithmetic on data, only shift/insert. cnt and len never exceed N.

Decomposition:
- Shared package (vec_pkg): state enum {FILL, PAD, FULL}, default N/W constants, the CW derivation function.
- No sub-module is needed. The A and B shift registers are two instances of one generate-free always block pattern. An optional sub-module, packed_shift_reg (param N, W; shift_en, din, clear), is natural if the same shifter is reused for B and for future matrix-row packers.

Test Plan:
- N=3, W=8: feed (1,1),(2,2),(3,3) with in_last on the 3rd -> out_valid high the cycle after the 3rd accept, A=B=24'h010203, len=3; downstream dot product 14.
- Feed (10,10),(5,5) with in_last on the 2nd -> 1 PAD cycle with in_ready=0, then A=B=24'h0A0500, len=2; feed (2,2) alone with in_last -> 2 PAD cycles, A=24'h020000, len=1.
- Hold out_ready=0 for 5 cycles after FULL with in_valid=1 -> in_ready=0 throughout, A/B unchanged; then out_ready=1 for 1 cycle -> next cycle in_ready=1, A=B=0.
- Back-to-back vectors {1,2,3} then {10,5,2}, in_valid always 1, out_ready always 1 -> second packet A=24'h0A0502 with exactly one idle input cycle between vectors.
- Random in_valid gaps (50%) during fill -> same A/B as the gap-free run; cnt advances only on accept.
- Assert rst=0 asynchronously mid-fill (after 2 accepts, between clock edges) -> A=B=0, out_valid=0 immediately; after release, a full 3-element vector packs correctly from element 0.
